// File: rtl/pipeline_issue_ctrl_if.sv
// pipeline_issue_ctrl_if: request, flush, pipeline and response signals of the issue controller
interface pipeline_issue_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid, req_ready, flush_req, flush_ack, rsp_valid;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_REQ*ID_WIDTH-1:0] flush_req_id;
  logic [ID_WIDTH-1:0] req_id, pipe_id, pipe_flush_id, pout_id, rsp_id;
  logic [ADDRESS_WIDTH-1:0] pipe_address, pout_address, rsp_address;
  logic pipe_valid, pipe_flush, pipe_stall, pout_valid, rsp_ready, busy, err_orphan;
  modport master (
    input req_valid, req_address, flush_req, flush_req_id, pout_address, pout_id, pout_valid, rsp_ready,
    output req_ready, req_id, flush_ack, pipe_address, pipe_id, pipe_valid, pipe_flush, pipe_flush_id,
           pipe_stall, rsp_valid, rsp_address, rsp_id, busy, err_orphan
  );
  modport slave (
    output req_valid, req_address, flush_req, flush_req_id, pout_address, pout_id, pout_valid, rsp_ready,
    input req_ready, req_id, flush_ack, pipe_address, pipe_id, pipe_valid, pipe_flush, pipe_flush_id,
          pipe_stall, rsp_valid, rsp_address, rsp_id, busy, err_orphan
  );
endinterface

// File: rtl/pipeline_issue_ctrl.sv
// pipeline_issue_ctrl: issue arbitration, ID scoreboard, response routing and per-ID flush sequencing.
// Define ISSUE_RR_EN for round-robin issue arbitration; otherwise fixed priority (lowest index wins).
module pipeline_issue_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int NUM_REQ = 4,
  parameter int PIPE_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  pipeline_issue_ctrl_if.master bus
);
  localparam int NID = 1 << ID_WIDTH;
  localparam int RW = $clog2(NUM_REQ);
  localparam int CW = $clog2(PIPE_DEPTH + 1) + 1;
  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, ACK} state_t;
  state_t state, state_nx;
  logic [NID-1:0] busy_q, flushed_q;
  logic [RW-1:0] owner_q [NID];
  logic [RW-1:0] fl_req_q, fl_idx, gnt_idx;
  logic [ID_WIDTH-1:0] fl_id_q, fl_id, free_id;
  logic [CW-1:0] cnt_q;
  logic [ADDRESS_WIDTH-1:0] gnt_addr;
  logic free_ok, fl_any, fl_hit, gnt_found, grant_ok, pout_busy, pout_flushed, rsp_hit, err_q;
  always_comb begin
    free_ok = 1'b0;
    free_id = '0;
    for (int i = NID - 1; i >= 0; i--)
      if (!busy_q[i]) begin
        free_ok = 1'b1;
        free_id = ID_WIDTH'(i);
      end
    fl_any = 1'b0;
    fl_idx = '0;
    fl_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.flush_req[i]) begin
        fl_any = 1'b1;
        fl_idx = RW'(i);
        fl_id = bus.flush_req_id[i*ID_WIDTH +: ID_WIDTH];
      end
    fl_hit = busy_q[fl_id] && owner_q[fl_id] == fl_idx;
  end
`ifdef ISSUE_RR_EN
  logic [RW-1:0] rr_q;
  logic [2*NUM_REQ-1:0] rr_dbl;
  logic [NUM_REQ-1:0] rr_rot;
  assign rr_dbl = {bus.req_valid, bus.req_valid} >> rr_q;
  assign rr_rot = rr_dbl[NUM_REQ-1:0];
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rr_rot[i]) begin
        gnt_found = 1'b1;
        gnt_idx = RW'((int'(rr_q) + i) % NUM_REQ);
      end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) rr_q <= '0;
    else if (grant_ok) rr_q <= RW'((int'(gnt_idx) + 1) % NUM_REQ);
`else
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx = RW'(i);
      end
  end
`endif
  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_idx == RW'(i)) gnt_addr = bus.req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  end
  assign pout_busy = busy_q[bus.pout_id];
  assign pout_flushed = flushed_q[bus.pout_id];
  assign bus.pipe_stall = bus.pout_valid & ~bus.rsp_ready & ~pout_flushed;
  assign rsp_hit = bus.pout_valid & pout_busy & ~pout_flushed;
  // An accepted flush in the same cycle blocks issue, so flush wins over requesters
  assign grant_ok = gnt_found & free_ok & ~bus.pipe_stall & (state == IDLE) & ~fl_any;
  assign bus.req_ready = grant_ok ? NUM_REQ'(1) << gnt_idx : '0;
  assign bus.req_id = grant_ok ? free_id : '0;
  assign bus.rsp_valid = rsp_hit ? NUM_REQ'(1) << owner_q[bus.pout_id] : '0;
  assign bus.rsp_address = bus.pout_address;
  assign bus.rsp_id = bus.pout_id;
  assign bus.pipe_flush = state == FLUSH;
  assign bus.pipe_flush_id = state == FLUSH ? fl_id_q : '0;
  assign bus.flush_ack = state == ACK ? NUM_REQ'(1) << fl_req_q : '0;
  assign bus.busy = |busy_q || state != IDLE;
  assign bus.err_orphan = err_q;
  always_comb begin
    state_nx = state == IDLE  ? (fl_any ? (fl_hit ? FLUSH : ACK) : IDLE)
             : state == FLUSH ? DRAIN
             : state == DRAIN ? ((!bus.pipe_stall && cnt_q == CW'(PIPE_DEPTH)) ? ACK : DRAIN)
             : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      busy_q <= '0;
      flushed_q <= '0;
      fl_req_q <= '0;
      fl_id_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      bus.pipe_valid <= 1'b0;
      bus.pipe_address <= '0;
      bus.pipe_id <= '0;
      for (int i = 0; i < NID; i++) owner_q[i] <= '0;
    end else begin
      state <= state_nx;
      cnt_q <= state == DRAIN ? cnt_q + CW'(!bus.pipe_stall) : '0;
      err_q <= err_q | (bus.pout_valid & ~pout_busy);
      if (state == IDLE && fl_any) begin
        fl_req_q <= fl_idx;
        fl_id_q <= fl_id;
      end
      // Marking on acceptance lets a stalled response for this ID release the stall next cycle
      if (state == IDLE && fl_any && fl_hit) flushed_q[fl_id] <= 1'b1;
      if (rsp_hit && bus.rsp_ready) busy_q[bus.pout_id] <= 1'b0;
      if (grant_ok) begin
        busy_q[free_id] <= 1'b1;
        owner_q[free_id] <= gnt_idx;
      end
      if (state == ACK && flushed_q[fl_id_q]) begin
        busy_q[fl_id_q] <= 1'b0;
        flushed_q[fl_id_q] <= 1'b0;
      end
      if (!bus.pipe_stall) begin
        bus.pipe_valid <= grant_ok;
        if (grant_ok) begin
          bus.pipe_address <= gnt_addr;
          bus.pipe_id <= free_id;
        end
      end
    end
endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// tb_pipeline_issue_ctrl: vector table, directed flush/reset sequences and a randomized model check.
module tb_pipeline_issue_ctrl;
`ifdef ISSUE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk, reset;
  int n_chk, n_fail;
  pipeline_issue_ctrl_if #(.ADDRESS_WIDTH(32), .ID_WIDTH(4), .NUM_REQ(4)) bus();
  pipeline_issue_ctrl #(.ADDRESS_WIDTH(32), .ID_WIDTH(4), .NUM_REQ(4), .PIPE_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] rv; logic [31:0] addr; logic pv; logic [3:0] pid; logic rr;
    logic [3:0] e_ready; logic [3:0] e_id; logic e_pv; logic [3:0] e_pipe_id; logic [31:0] e_paddr;
    logic e_stall; logic [3:0] e_rsp; logic e_busy; logic e_err;
  } vec_t;
  vec_t vt [16];

  bit m_busy [16];
  int m_owner [16];
  int rr_ptr, m_pid, win, fid, ack_at;
  bit m_pv, grant, stall, hit;
  logic [31:0] m_paddr;
  logic [3:0] rv;
  int busy_ids [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_address = '0; bus.flush_req = '0; bus.flush_req_id = '0;
    bus.pout_address = '0; bus.pout_id = '0; bus.pout_valid = 1'b0; bus.rsp_ready = 1'b1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    //          rv    addr      pv  pid   rr  | ready id   pv  pid  paddr     st  rsp  busy err
    vt[0]  = '{4'h0, 32'h0,   0, 4'd0, 1,  4'h0, 4'd0, 0, 4'd0, 32'h0,   0, 4'h0, 0, 0};
    vt[1]  = '{4'h1, 32'h100, 0, 4'd0, 1,  4'h1, 4'd0, 0, 4'd0, 32'h0,   0, 4'h0, 0, 0};
    vt[2]  = '{4'h0, 32'h0,   0, 4'd0, 1,  4'h0, 4'd0, 1, 4'd0, 32'h100, 0, 4'h0, 1, 0};
    vt[3]  = '{4'h0, 32'h0,   1, 4'd0, 1,  4'h0, 4'd0, 0, 4'd0, 32'h100, 0, 4'h1, 1, 0};
    vt[4]  = '{4'h0, 32'h0,   0, 4'd0, 1,  4'h0, 4'd0, 0, 4'd0, 32'h100, 0, 4'h0, 0, 0};
    vt[5]  = '{4'h4, 32'h200, 0, 4'd0, 1,  4'h4, 4'd0, 0, 4'd0, 32'h100, 0, 4'h0, 0, 0};
    vt[6]  = '{4'h2, 32'h300, 0, 4'd0, 1,  4'h2, 4'd1, 1, 4'd0, 32'h202, 0, 4'h0, 1, 0};
    vt[7]  = '{4'h0, 32'h0,   1, 4'd1, 0,  4'h0, 4'd0, 1, 4'd1, 32'h301, 1, 4'h2, 1, 0};
    vt[8]  = '{4'h1, 32'h400, 1, 4'd1, 0,  4'h0, 4'd0, 1, 4'd1, 32'h301, 1, 4'h2, 1, 0};
    vt[9]  = '{4'h1, 32'h400, 1, 4'd1, 1,  4'h1, 4'd2, 1, 4'd1, 32'h301, 0, 4'h2, 1, 0};
    vt[10] = '{4'h0, 32'h0,   1, 4'd0, 1,  4'h0, 4'd0, 1, 4'd2, 32'h400, 0, 4'h4, 1, 0};
    vt[11] = '{4'h0, 32'h0,   0, 4'd0, 1,  4'h0, 4'd0, 0, 4'd2, 32'h400, 0, 4'h0, 1, 0};
    vt[12] = '{4'h0, 32'h0,   1, 4'd2, 1,  4'h0, 4'd0, 0, 4'd2, 32'h400, 0, 4'h1, 1, 0};
    vt[13] = '{4'h0, 32'h0,   0, 4'd0, 1,  4'h0, 4'd0, 0, 4'd2, 32'h400, 0, 4'h0, 0, 0};
    vt[14] = '{4'h0, 32'h0,   1, 4'd7, 1,  4'h0, 4'd0, 0, 4'd2, 32'h400, 0, 4'h0, 0, 0};
    vt[15] = '{4'h0, 32'h0,   0, 4'd0, 1,  4'h0, 4'd0, 0, 4'd2, 32'h400, 0, 4'h0, 0, 1};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = vt[i].rv;
      for (int r = 0; r < 4; r++) bus.req_address[r*32 +: 32] = vt[i].addr | r;
      bus.pout_valid = vt[i].pv; bus.pout_id = vt[i].pid; bus.rsp_ready = vt[i].rr;
      bus.pout_address = 32'hA000 | vt[i].pid;
      #2;
      chk($sformatf("vec%0d_ready", i), bus.req_ready, vt[i].e_ready);
      chk($sformatf("vec%0d_req_id", i), bus.req_id, vt[i].e_id);
      chk($sformatf("vec%0d_pipe_valid", i), bus.pipe_valid, vt[i].e_pv);
      chk($sformatf("vec%0d_pipe_id", i), bus.pipe_id, vt[i].e_pipe_id);
      chk($sformatf("vec%0d_pipe_address", i), bus.pipe_address, vt[i].e_paddr);
      chk($sformatf("vec%0d_stall", i), bus.pipe_stall, vt[i].e_stall);
      chk($sformatf("vec%0d_rsp_valid", i), bus.rsp_valid, vt[i].e_rsp);
      chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].e_busy);
      chk($sformatf("vec%0d_err_orphan", i), bus.err_orphan, vt[i].e_err);
      step();
    end

    // arbitration with all requesters held valid
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 4'hF;
      #2;
      chk("arb_ready", bus.req_ready, RR ? 4'b1 << (i % 4) : 4'b1);
      chk("arb_req_id", bus.req_id, i);
      step();
    end

    // exhaust all IDs, then free one
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = 4'h1;
      #2;
      chk("fill_ready", bus.req_ready, 4'h1);
      chk("fill_req_id", bus.req_id, i);
      step();
    end
    #2;
    chk("full_ready", bus.req_ready, 4'h0);
    step();
    bus.pout_valid = 1'b1; bus.pout_id = 4'd9;
    #2;
    chk("full_retire_rsp", bus.rsp_valid, 4'h1);
    chk("full_retire_ready", bus.req_ready, 4'h0);
    step();
    bus.pout_valid = 1'b0;
    #2;
    chk("freed_ready", bus.req_ready, 4'h1);
    chk("freed_req_id", bus.req_id, 9);
    step();
    #2;
    chk("refull_ready", bus.req_ready, 4'h0);

    // requester 2 flushes its busy ID 5
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = (i < 5) ? 4'b0001 : 4'b0100;
      #2;
      chk("c_alloc_id", bus.req_id, i);
      step();
    end
    bus.req_valid = 4'b0001; bus.flush_req = 4'b0100; bus.flush_req_id = 16'h0500;
    #2;
    chk("c_t0_ready", bus.req_ready, 4'h0);
    chk("c_t0_pipe_flush", bus.pipe_flush, 1'b0);
    step();
    for (int k = 1; k <= 11; k++) begin
      bus.pout_valid = (k == 5); bus.pout_id = 4'd5; bus.rsp_ready = 1'b0;
      #2;
      chk($sformatf("c_pipe_flush_k%0d", k), bus.pipe_flush, k == 1);
      if (k == 1) chk("c_pipe_flush_id", bus.pipe_flush_id, 5);
      chk($sformatf("c_ack_k%0d", k), bus.flush_ack, k == 11 ? 4'b0100 : 4'h0);
      chk("c_no_grant", bus.req_ready, 4'h0);
      if (k == 5) begin
        chk("c_drop_stall", bus.pipe_stall, 1'b0);
        chk("c_drop_rsp", bus.rsp_valid, 4'h0);
      end
      step();
    end
    bus.flush_req = '0; bus.pout_valid = 1'b0; bus.rsp_ready = 1'b1;
    #2;
    chk("c_reuse_ready", bus.req_ready, 4'h1);
    chk("c_reuse_id", bus.req_id, 5);
    chk("c_err", bus.err_orphan, 1'b0);

    // flush of a non-owned ID, then reset in the middle of a drain
    do_reset();
    bus.req_valid = 4'h1;
    step();
    bus.req_valid = 4'h0; bus.flush_req = 4'b0010; bus.flush_req_id = 16'h0000;
    #2;
    chk("d_ack_t0", bus.flush_ack, 4'h0);
    step();
    #2;
    chk("d_ack_t1", bus.flush_ack, 4'b0010);
    chk("d_no_pipe_flush", bus.pipe_flush, 1'b0);
    step();
    bus.flush_req = '0;
    #2;
    chk("d_still_busy", bus.busy, 1'b1);
    step();
    bus.flush_req = 4'b0001;
    step();
    #2;
    chk("d_own_pipe_flush", bus.pipe_flush, 1'b1);
    repeat (4) step();
    reset = 1'b0;
    #2;
    chk("d_rst_ready", bus.req_ready, 4'h0);
    chk("d_rst_req_id", bus.req_id, 0);
    chk("d_rst_pipe_valid", bus.pipe_valid, 1'b0);
    chk("d_rst_pipe_flush", bus.pipe_flush, 1'b0);
    chk("d_rst_flush_id", bus.pipe_flush_id, 0);
    chk("d_rst_ack", bus.flush_ack, 4'h0);
    chk("d_rst_busy", bus.busy, 1'b0);
    chk("d_rst_rsp", bus.rsp_valid, 4'h0);
    chk("d_rst_stall", bus.pipe_stall, 1'b0);
    bus.flush_req = '0;
    step();
    reset = 1'b1;
    #2;
    chk("d_post_busy", bus.busy, 1'b0);
    bus.req_valid = 4'h1;
    #1;
    chk("d_post_ready", bus.req_ready, 4'h1);
    chk("d_post_req_id", bus.req_id, 0);

    // flush accepted while its response is stalled
    do_reset();
    bus.req_valid = 4'h1;
    step();
    bus.req_valid = 4'h0; bus.pout_valid = 1'b1; bus.pout_id = 4'd0; bus.rsp_ready = 1'b0;
    bus.flush_req = 4'h1; bus.flush_req_id = 16'h0000;
    #2;
    chk("e_stall_t0", bus.pipe_stall, 1'b1);
    chk("e_rsp_t0", bus.rsp_valid, 4'h1);
    step();
    #2;
    chk("e_stall_t1", bus.pipe_stall, 1'b0);
    chk("e_rsp_t1", bus.rsp_valid, 4'h0);
    ack_at = -1;
    for (int k = 2; k < 20 && ack_at < 0; k++) begin
      step();
      #2;
      if (bus.flush_ack == 4'h1) ack_at = k;
    end
    chk("e_ack_cycle", ack_at, 11);
    bus.flush_req = '0; bus.pout_valid = 1'b0; bus.rsp_ready = 1'b1;
    step();
    #2;
    chk("e_busy_after", bus.busy, 1'b0);
    chk("e_err_after", bus.err_orphan, 1'b0);

    // randomized issue/retire traffic against the scoreboard model
    do_reset();
    for (int i = 0; i < 16; i++) begin m_busy[i] = 0; m_owner[i] = 0; end
    rr_ptr = 0; m_pv = 0; m_pid = 0; m_paddr = '0;
    for (int c = 0; c < 3000; c++) begin
      busy_ids.delete();
      for (int i = 0; i < 16; i++) if (m_busy[i]) busy_ids.push_back(i);
      rv = 4'($urandom_range(0, 15));
      bus.req_valid = rv;
      for (int r = 0; r < 4; r++) bus.req_address[r*32 +: 32] = $urandom;
      if (busy_ids.size() > 0 && $urandom_range(0, 2) != 0) begin
        bus.pout_valid = 1'b1;
        bus.pout_id = 4'(busy_ids[$urandom_range(0, busy_ids.size() - 1)]);
      end else begin
        bus.pout_valid = 1'b0;
        bus.pout_id = 4'($urandom_range(0, 15));
      end
      bus.pout_address = $urandom;
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      stall = bus.pout_valid && !bus.rsp_ready;
      fid = -1;
      for (int i = 15; i >= 0; i--) if (!m_busy[i]) fid = i;
      win = -1;
      for (int i = 0; i < 4; i++)
        if (win < 0 && rv[(RR ? rr_ptr + i : i) % 4]) win = (RR ? rr_ptr + i : i) % 4;
      grant = win >= 0 && fid >= 0 && !stall;
      hit = bus.pout_valid && m_busy[bus.pout_id];
      #2;
      chk("rnd_ready", bus.req_ready, grant ? 1 << win : 0);
      chk("rnd_req_id", bus.req_id, grant ? fid : 0);
      chk("rnd_rsp_valid", bus.rsp_valid, hit ? 1 << m_owner[bus.pout_id] : 0);
      chk("rnd_stall", bus.pipe_stall, stall);
      chk("rnd_pipe_valid", bus.pipe_valid, m_pv);
      chk("rnd_pipe_id", bus.pipe_id, m_pid);
      chk("rnd_pipe_address", bus.pipe_address, m_paddr);
      chk("rnd_rsp_address", bus.rsp_address, bus.pout_address);
      chk("rnd_busy", bus.busy, busy_ids.size() > 0);
      if (!stall) begin
        m_pv = grant;
        if (grant) begin m_pid = fid; m_paddr = bus.req_address[win*32 +: 32]; end
      end
      if (grant) begin m_busy[fid] = 1; m_owner[fid] = win; rr_ptr = (win + 1) % 4; end
      if (hit && bus.rsp_ready) m_busy[bus.pout_id] = 0;
      step();
    end
    #2;
    chk("rnd_err_orphan", bus.err_orphan, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
